// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package instruction_fetcher_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned IDX_W    = 2;
  localparam int unsigned ROM_SIZE = 64;

  typedef enum logic [1:0] {
    FETCH_STATE_FETCH = 2'd0,
    FETCH_STATE_VALID = 2'd1,
    FETCH_STATE_FAULT = 2'd2
  } fetch_state_e;

  localparam logic FAULT_CAUSE_ILLEGAL    = 1'b0;
  localparam logic FAULT_CAUSE_MISALIGNED = 1'b1;

  typedef struct packed {
    logic            cause;
    logic [XLEN-1:0] address;
  } fault_info_t;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetcher.sv
// Fetch stage: reads four ROM bytes per instruction, assembles a little-endian
// word, offers it on a valid/ready handshake and stops on fetch faults.
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic [XLEN-1:0] rom_address,
  input  logic [7:0]      rom_read_data,
  input  logic            rom_illegal_address,
  input  logic            pc_load,
  input  logic [XLEN-1:0] pc_load_value,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            fetch_fault,
  output logic            fault_cause,
  output logic [XLEN-1:0] fault_address
);

  fetch_state_e       state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [XLEN-1:0]    instr_q, instr_d;
  logic [XLEN-1:0]    instr_pc_q, instr_pc_d;
  fault_info_t        fault_q, fault_d;
  logic               instr_valid_q, instr_valid_d;
  logic               fetch_fault_q, fetch_fault_d;
  logic [XLEN-1:0]    fetch_addr;
  logic               load_aligned;

  assign fetch_addr   = pc_q + XLEN'(idx_q);
  assign load_aligned = is_word_aligned(pc_load_value);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH_STATE_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a redirect overrides whatever the current state wants
  always_comb begin
    state_d = state_q;
    if (pc_load) begin
      state_d = load_aligned ? FETCH_STATE_FETCH : FETCH_STATE_FAULT;
    end else begin
      unique case (state_q)
        FETCH_STATE_FETCH: begin
          if (rom_illegal_address) begin
            state_d = FETCH_STATE_FAULT;
          end else if (idx_q == IDX_W'(3)) begin
            state_d = FETCH_STATE_VALID;
          end
        end
        FETCH_STATE_VALID: begin
          if (instr_ready) begin
            state_d = FETCH_STATE_FETCH;
          end
        end
        FETCH_STATE_FAULT: state_d = FETCH_STATE_FAULT;
        default:           state_d = FETCH_STATE_FETCH;
      endcase
    end
  end

  // Outputs: ROM address from registered state, flags precomputed from next state
  always_comb begin
    rom_address   = pc_q;
    instr_valid_d = 1'b0;
    fetch_fault_d = 1'b0;
    if (state_q == FETCH_STATE_FETCH) begin
      rom_address = fetch_addr;
    end
    if (state_d == FETCH_STATE_VALID) begin
      instr_valid_d = 1'b1;
    end
    if (state_d == FETCH_STATE_FAULT) begin
      fetch_fault_d = 1'b1;
    end
  end

  // Datapath next values for pc, byte index, assembled word and fault record
  always_comb begin
    pc_d       = pc_q;
    idx_d      = idx_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    fault_d    = fault_q;
    if (pc_load) begin
      idx_d = '0;
      if (load_aligned) begin
        pc_d = pc_load_value;
      end else begin
        fault_d.cause   = FAULT_CAUSE_MISALIGNED;
        fault_d.address = pc_load_value;
      end
    end else begin
      unique case (state_q)
        FETCH_STATE_FETCH: begin
          if (rom_illegal_address) begin
            fault_d.cause   = FAULT_CAUSE_ILLEGAL;
            fault_d.address = fetch_addr;
          end else begin
            instr_d[{idx_q, 3'b000} +: BYTE_W] = rom_read_data;
            if (idx_q == IDX_W'(3)) begin
              instr_pc_d = pc_q;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
        FETCH_STATE_VALID: begin
          if (instr_ready) begin
            pc_d  = pc_q + XLEN'(4);
            idx_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath and registered-output flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_VECTOR;
      idx_q         <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      fault_q       <= '0;
      instr_valid_q <= 1'b0;
      fetch_fault_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      idx_q         <= idx_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      fault_q       <= fault_d;
      instr_valid_q <= instr_valid_d;
      fetch_fault_q <= fetch_fault_d;
    end
  end

  assign instr         = instr_q;
  assign instr_pc      = instr_pc_q;
  assign instr_valid   = instr_valid_q;
  assign fetch_fault   = fetch_fault_q;
  assign fault_cause   = fault_q.cause;
  assign fault_address = fault_q.address;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Directed, table-driven bench for instruction_fetcher with a 64-byte ROM model.
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  localparam int unsigned AW = $clog2(ROM_SIZE);

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] rom_address;
  logic [7:0]  rom_read_data;
  logic        rom_illegal_address;
  logic        pc_load;
  logic [31:0] pc_load_value;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_fault;
  logic        fault_cause;
  logic [31:0] fault_address;

  logic [7:0]  rom [ROM_SIZE];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  assign rom_illegal_address = (rom_address >= 32'(ROM_SIZE));
  assign rom_read_data = rom_illegal_address ? 8'h00 : rom[rom_address[AW-1:0]];

  instruction_fetcher #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk                 (clk),
    .reset_n             (reset_n),
    .rom_address         (rom_address),
    .rom_read_data       (rom_read_data),
    .rom_illegal_address (rom_illegal_address),
    .pc_load             (pc_load),
    .pc_load_value       (pc_load_value),
    .instr_valid         (instr_valid),
    .instr_ready         (instr_ready),
    .instr               (instr),
    .instr_pc            (instr_pc),
    .fetch_fault         (fetch_fault),
    .fault_cause         (fault_cause),
    .fault_address       (fault_address)
  );

  typedef struct {
    logic        load;
    logic [31:0] lval;
    logic        ready;
    logic        e_valid;
    logic        e_fault;
    logic        e_cause;
    logic [31:0] e_addr;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic [31:0] e_faddr;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] exp_word(input int unsigned a);
    return {rom[a+3], rom[a+2], rom[a+1], rom[a]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addv(input logic load, input logic [31:0] lval, input logic ready,
                      input logic ev, input logic ef, input logic ec, input logic [31:0] ea,
                      input logic [31:0] ei, input logic [31:0] ep, input logic [31:0] efa);
    vec_t v;
    v.load = load; v.lval = lval; v.ready = ready;
    v.e_valid = ev; v.e_fault = ef; v.e_cause = ec; v.e_addr = ea;
    v.e_instr = ei; v.e_ipc = ep; v.e_faddr = efa;
    vecs.push_back(v);
  endtask

  task automatic step(input logic load, input logic [31:0] lval, input logic ready);
    pc_load = load; pc_load_value = lval; instr_ready = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_reset(input string tag);
    chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
    chk({tag, "_fault"}, 32'(fetch_fault), 32'd0);
    chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
    chk({tag, "_faddr"}, fault_address, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_ipc"}, instr_pc, 32'd0);
    chk({tag, "_romaddr"}, rom_address, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < int'(ROM_SIZE); i++) rom[i] = 8'(i * 37 + 11);
    rom[0] = 8'h13; rom[1] = 8'h05; rom[2] = 8'hA0; rom[3] = 8'h00;

    // load lval ready | valid fault cause romaddr instr ipc faddr
    addv(0, 0, 1, 0, 0, 0, 32'h01, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h02, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h03, 0, 0, 0);
    addv(0, 0, 1, 1, 0, 0, 32'h00, 32'h00A0_0513, 32'h00, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h04, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h05, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h06, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h07, 0, 0, 0);
    addv(0, 0, 1, 1, 0, 0, 32'h04, exp_word(4), 32'h04, 0);
    addv(0, 0, 0, 1, 0, 0, 32'h04, exp_word(4), 32'h04, 0);
    addv(0, 0, 0, 1, 0, 0, 32'h04, exp_word(4), 32'h04, 0);
    addv(0, 0, 0, 1, 0, 0, 32'h04, exp_word(4), 32'h04, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h08, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h09, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h0A, 0, 0, 0);
    addv(1, 32'h10, 1, 0, 0, 0, 32'h10, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h11, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h12, 0, 0, 0);
    addv(0, 0, 1, 0, 0, 0, 32'h13, 0, 0, 0);
    addv(0, 0, 0, 1, 0, 0, 32'h10, exp_word(16), 32'h10, 0);
    addv(1, 32'h06, 0, 0, 1, 1, 32'h10, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 1, 1, 32'h10, 0, 0, 32'h06);
    addv(1, 32'h08, 1, 0, 0, 1, 32'h08, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 0, 1, 32'h09, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 0, 1, 32'h0A, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 0, 1, 32'h0B, 0, 0, 32'h06);
    addv(0, 0, 1, 1, 0, 1, 32'h08, exp_word(8), 32'h08, 32'h06);
    addv(1, 32'h3C, 1, 0, 0, 1, 32'h3C, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 0, 1, 32'h3D, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 0, 1, 32'h3E, 0, 0, 32'h06);
    addv(0, 0, 0, 0, 0, 1, 32'h3F, 0, 0, 32'h06);
    addv(0, 0, 1, 1, 0, 1, 32'h3C, exp_word(60), 32'h3C, 32'h06);
    addv(0, 0, 1, 0, 0, 1, 32'h40, 0, 0, 32'h06);
    addv(0, 0, 1, 0, 1, 0, 32'h40, 0, 0, 32'h40);
    addv(0, 0, 1, 0, 1, 0, 32'h40, 0, 0, 32'h40);

    reset_n = 1'b0; pc_load = 1'b0; pc_load_value = '0; instr_ready = 1'b0;
    #12;
    chk_all_reset("reset");
    reset_n = 1'b1;

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("v%0d", i);
      step(vecs[i].load, vecs[i].lval, vecs[i].ready);
      chk({nm, "_valid"}, 32'(instr_valid), 32'(vecs[i].e_valid));
      chk({nm, "_fault"}, 32'(fetch_fault), 32'(vecs[i].e_fault));
      chk({nm, "_cause"}, 32'(fault_cause), 32'(vecs[i].e_cause));
      chk({nm, "_romaddr"}, rom_address, vecs[i].e_addr);
      chk({nm, "_faddr"}, fault_address, vecs[i].e_faddr);
      if (vecs[i].e_valid) begin
        chk({nm, "_instr"}, instr, vecs[i].e_instr);
        chk({nm, "_ipc"}, instr_pc, vecs[i].e_ipc);
      end
    end

    // Recover from the illegal-address fault, then reset asynchronously mid-fetch
    step(1'b1, 32'h0, 1'b1);
    chk("recover_fault", 32'(fetch_fault), 32'd0);
    step(1'b0, 32'h0, 1'b1);
    chk("midfetch_romaddr", rom_address, 32'h1);
    #3 reset_n = 1'b0;
    #1;
    chk_all_reset("async_reset");
    #2 reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 32'h0, 1'b1);
      chk($sformatf("restart_romaddr%0d", c), rom_address, 32'(c + 1));
    end
    step(1'b0, 32'h0, 1'b1);
    chk("restart_valid", 32'(instr_valid), 32'd1);
    chk("restart_instr", instr, 32'h00A0_0513);
    chk("restart_ipc", instr_pc, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
